dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the core's AHB-Lite-style data bus.
- Acts as the target for single loads/stores and for the beat-by-beat LDM/STM/PUSH/POP transfers that the decode/execute path issues with HSIZE and write enable.
- Holds a word-organised RAM with byte-lane writes, configurable wait states, and error responses.
- Sits between the pipeline's data-bus initiator and the system bus fabric.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- BASE_ADDR, 32'h2000_0000: first byte address decoded by this block.
- WAIT_STATES, 0: extra data-phase cycles (HREADYOUT low) per accepted transfer, 0..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address, address phase.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others reserved.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-wide ready; the address phase is sampled only when this is high.
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.
- HREADYOUT  out  1  responder ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (rst=0 at an edge): HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, state=IDLE, pending transfer cleared. RAM contents are not reset.
- Accept condition: HSEL & HREADY & HTRANS[1] on an edge. The block then latches HADDR, HWRITE, HSIZE and moves to DATA. BUSY and IDLE are accepted with a zero-wait OKAY and no RAM access.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE -> DATA on accept.
- DATA:
  - Wait counter loads WAIT_STATES on accept; HREADYOUT=0 while counter != 0; decrement each cycle.
  - When counter == 0, HREADYOUT=1 and the transfer completes on that edge.
  - If a new accept occurs on the completing edge, stay in DATA (back-to-back pipelining); otherwise go to IDLE.
- Latency: with WAIT_STATES=0, read data appears in the cycle after the address phase, so there is one address-to-data cycle per beat. Total data-phase length is 1+WAIT_STATES cycles.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2
  - in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS
- Alignment:
  - halfword needs addr[0]=0; word needs addr[1:0]=0.
  - HSIZE values above 010 are treated as misaligned.
- Write, on the completing edge only:
  - byte: lane addr[1:0] written from HWDATA[8*lane+7 : 8*lane].
  - halfword: lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 lanes.
  - Data is taken from HWDATA in the data phase, not the address phase.
- Read:
  - HRDATA = full 32-bit word at the latched index, driven while HREADYOUT=1 in the read data phase.
  - The initiator extracts and extends the lanes itself.
  - Outside read data phases HRDATA holds its last value.
- Read-after-write: a read whose address phase overlaps the preceding write's data phase returns the newly written data. The write commits before the read data is sampled.
- Faulting transfer (misaligned or out of range): no RAM write; handling per the optional feature below.
- Reset mid-transfer: the pending write is discarded and the state is forced to IDLE.
- An address phase presented while HREADY=0 is ignored.

Optional Feature:
- Macro DMEM_ERR_RESP_EN.
- When defined: a faulting transfer gives a two-cycle ERROR response.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - Then IDLE; an address phase accepted during ERR2 is dropped.
  - No wait states are inserted before ERR1.
- When undefined: faults complete as OKAY after the normal wait states. Writes are dropped and reads return 32'h0. The ERR states are not built.

Test Plan:
- WAIT_STATES=0, word write 32'hDEAD_BEEF to 0x2000_0010, then word read of the same address back-to-back -> HRDATA=32'hDEAD_BEEF one cycle after the read address phase, HRESP=0.
- Byte write 8'h5A to 0x2000_0013 over a word holding 32'h1122_3344 -> a subsequent read returns 32'h5A22_3344.
- WAIT_STATES=2, STM-style 4 SEQ word writes from 0x2000_0040 -> each beat holds HREADYOUT low for 2 cycles; readback of 0x40..0x4C matches the written data.
- DMEM_ERR_RESP_EN defined: halfword write to 0x2000_0001 -> HREADYOUT 0 then 1, with HRESP=1 in both cycles; the RAM word is unchanged.
- DMEM_ERR_RESP_EN undefined: word read at 0x2000_1000 with DEPTH_WORDS=1024 -> OKAY with HRDATA=0.
- rst driven low during the wait state of a word write to 0x2000_0020 -> outputs return to reset values at the next edge and the RAM word is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder on the AHB-Lite-style data bus: word RAM, byte-lane writes, wait states.
// Optional macro DMEM_ERR_RESP_EN: faulting transfers get a two-cycle ERROR response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0]  WaitInit = 3'(WAIT_STATES);
`ifdef DMEM_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;
`else
  localparam bit ErrEn = 1'b0;
  typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            ready_q;
  logic            resp_q;
  logic [31:0]     rdata_q;
  logic            write_q;
  logic            ok_q;
  logic [3:0]      be_q;
  logic [AW-1:0]   idx_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [29:0]     word_off;
  logic            in_range;
  logic            aligned;
  logic            addr_ok;
  logic [3:0]      be_new;
  logic [AW-1:0]   idx_new;
  logic            slot_open;
  logic            accept;
  logic            done;
  logic            wr_en;
  logic            rd_load;
  logic            rd_ok;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;
  logic            unused_htrans;

  assign unused_htrans = HTRANS[0];

  // Address-phase decode
  assign word_off = 30'((HADDR - BASE_ADDR) >> 2);
  assign in_range = (HADDR >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
  assign idx_new  = word_off[AW-1:0];
  assign addr_ok  = in_range && aligned;

  always_comb begin
    aligned = 1'b0;
    be_new  = 4'b0000;
    case (HSIZE)
      3'b000: begin
        aligned = 1'b1;
        be_new  = 4'b0001 << HADDR[1:0];
      end
      3'b001: begin
        aligned = ~HADDR[0];
        be_new  = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        aligned = (HADDR[1:0] == 2'b00);
        be_new  = 4'b1111;
      end
      default: begin
        aligned = 1'b0;
        be_new  = 4'b0000;
      end
    endcase
  end

  // A new address phase is only taken when idle or on the completing edge of a data phase
  assign slot_open = (state_q == StIdle) || ((state_q == StData) && (cnt_q == 3'd0));
  assign accept    = HSEL && HREADY && HTRANS[1] && slot_open;
  assign done      = (state_q == StData) && (cnt_q == 3'd0);
  assign wr_en     = rst && done && write_q && ok_q;

  // Read data is captured on the edge entering the final data-phase cycle
  always_comb begin
    rd_load = 1'b0;
    rd_ok   = 1'b0;
    rd_idx  = idx_q;
    if ((state_q == StData) && (cnt_q == 3'd1) && !write_q) begin
      rd_load = 1'b1;
      rd_ok   = ok_q;
      rd_idx  = idx_q;
    end else if (accept && !HWRITE && (WaitInit == 3'd0) && (addr_ok || !ErrEn)) begin
      rd_load = 1'b1;
      rd_ok   = addr_ok;
      rd_idx  = idx_new;
    end
  end

  // Forward lanes of a write committing on the same edge so read-after-write sees new data
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_en && (idx_q == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          rd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= 32'h0;
      write_q <= 1'b0;
      ok_q    <= 1'b0;
      be_q    <= 4'b0000;
      idx_q   <= '0;
    end else begin
      if (rd_load) begin
        rdata_q <= rd_ok ? rd_word : 32'h0;
      end
      case (state_q)
        StIdle, StData: begin
          if ((state_q == StData) && (cnt_q != 3'd0)) begin
            cnt_q   <= cnt_q - 3'd1;
            ready_q <= (cnt_q == 3'd1);
            resp_q  <= 1'b0;
          end else if (accept) begin
            idx_q   <= idx_new;
            write_q <= HWRITE;
            be_q    <= be_new;
            ok_q    <= addr_ok;
            if (ErrEn && !addr_ok) begin
`ifdef DMEM_ERR_RESP_EN
              state_q <= StErr1;
`endif
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              state_q <= StData;
              cnt_q   <= WaitInit;
              ready_q <= (WaitInit == 3'd0);
              resp_q  <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
`ifdef DMEM_ERR_RESP_EN
        StErr1: begin
          state_q <= StErr2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        StErr2: begin
          // Any address phase seen here is dropped
          state_q <= StIdle;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one zero-wait and one two-wait instance on a shared bus.
module tb_dmem_responder;

  localparam logic [31:0] Base = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel1, hwrite, hready_gate;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1, hresp0, hresp1;
  logic        hready0, hready1;
  int          errors = 0;
  int          checks = 0;

  assign hready0 = hreadyout0 & hready_gate;
  assign hready1 = hreadyout1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(Base), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0), .HRDATA(hrdata0),
    .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(Base), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready1), .HRDATA(hrdata1),
    .HREADYOUT(hreadyout1), .HRESP(hresp1)
  );

  task automatic drive_idle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic set_addr(input int s, input logic [31:0] a, input logic wr,
                          input logic [2:0] sz, input logic [1:0] tr);
    hsel0  = (s == 0);
    hsel1  = (s == 1);
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    htrans = tr;
  endtask

  // Single non-pipelined transfer; waits counts data-phase cycles with HREADYOUT low (bounded)
  task automatic bus_xfer(input int s, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd, output int waits,
                          output logic resp_first, output logic resp_last,
                          output logic [31:0] rd);
    set_addr(s, a, wr, sz, 2'b10);
    @(posedge clk); #1;
    drive_idle();
    hwdata = wd;
    waits  = 0;
    @(negedge clk);
    resp_first = (s == 0) ? hresp0 : hresp1;
    while ((((s == 0) ? hreadyout0 : hreadyout1) == 1'b0) && (waits < 20)) begin
      waits++;
      @(negedge clk);
    end
    resp_last = (s == 0) ? hresp0 : hresp1;
    rd        = (s == 0) ? hrdata0 : hrdata1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hready_gate = 1'b1;
    drive_idle();
    haddr  = 32'h0;
    hwdata = 32'h0;
    hsize  = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hreadyout0 !== 1'b1) begin errors++;
      $display("FAIL reset_ready0: got %0b want 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++;
      $display("FAIL reset_resp0: got %0b want 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++;
      $display("FAIL reset_rdata0: got %h want 00000000", hrdata0); end
    checks++; if (hreadyout1 !== 1'b1) begin errors++;
      $display("FAIL reset_ready1: got %0b want 1", hreadyout1); end
    checks++; if (hresp1 !== 1'b0) begin errors++;
      $display("FAIL reset_resp1: got %0b want 0", hresp1); end
    checks++; if (hrdata1 !== 32'h0) begin errors++;
      $display("FAIL reset_rdata1: got %h want 00000000", hrdata1); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    set_addr(0, Base + 32'h10, 1'b1, 3'b010, 2'b10);
    @(posedge clk); #1;
    hwdata = 32'hDEAD_BEEF;
    set_addr(0, Base + 32'h10, 1'b0, 3'b010, 2'b10);
    @(negedge clk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++;
      $display("FAIL b2b_write_ready: got %0b want 1", hreadyout0); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if (hrdata0 !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL b2b_read_data: got %h want deadbeef", hrdata0); end
    checks++; if (hresp0 !== 1'b0) begin errors++;
      $display("FAIL b2b_read_resp: got %0b want 0", hresp0); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_lanes();
    int w; logic rf, rl; logic [31:0] rd;
    bus_xfer(0, 1'b1, Base + 32'h10, 3'b010, 32'h1122_3344, w, rf, rl, rd);
    bus_xfer(0, 1'b1, Base + 32'h13, 3'b000, 32'h5AA5_A5A5, w, rf, rl, rd);
    bus_xfer(0, 1'b0, Base + 32'h10, 3'b010, 32'h0, w, rf, rl, rd);
    checks++; if (rd !== 32'h5A22_3344) begin errors++;
      $display("FAIL byte_write: got %h want 5a223344", rd); end
    bus_xfer(0, 1'b1, Base + 32'h14, 3'b010, 32'h5566_7788, w, rf, rl, rd);
    bus_xfer(0, 1'b1, Base + 32'h16, 3'b001, 32'hABCD_1111, w, rf, rl, rd);
    bus_xfer(0, 1'b0, Base + 32'h14, 3'b010, 32'h0, w, rf, rl, rd);
    checks++; if (rd !== 32'hABCD_7788) begin errors++;
      $display("FAIL half_write: got %h want abcd7788", rd); end
    checks++; if (w !== 0) begin errors++;
      $display("FAIL zero_wait_read: got %0d want 0", w); end
  endtask

  task automatic test_stm_wait_states();
    logic [31:0] stm_data [4];
    int lows; int w; logic rf, rl; logic [31:0] rd;
    stm_data = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) set_addr(1, Base + 32'h40 + 32'(4 * i), 1'b1, 3'b010, (i == 0) ? 2'b10 : 2'b11);
      else drive_idle();
      if (i > 0) hwdata = stm_data[i-1];
      lows = 0;
      @(negedge clk);
      while (!hreadyout1 && (lows < 20)) begin
        lows++;
        @(negedge clk);
      end
      if (i > 0) begin
        checks++; if (lows !== 2) begin errors++;
          $display("FAIL stm_beat%0d_waits: got %0d want 2", i - 1, lows); end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1, 1'b0, Base + 32'h40 + 32'(4 * i), 3'b010, 32'h0, w, rf, rl, rd);
      checks++; if (rd !== stm_data[i]) begin errors++;
        $display("FAIL stm_readback%0d: got %h want %h", i, rd, stm_data[i]); end
      checks++; if (w !== 2) begin errors++;
        $display("FAIL stm_read_waits%0d: got %0d want 2", i, w); end
    end
  endtask

  task automatic test_fault_align();
    int w; logic rf, rl; logic [31:0] rd;
    int exp_w; logic exp_r;
`ifdef DMEM_ERR_RESP_EN
    exp_w = 1; exp_r = 1'b1;
`else
    exp_w = 0; exp_r = 1'b0;
`endif
    bus_xfer(0, 1'b1, Base, 3'b010, 32'hCAFE_1234, w, rf, rl, rd);
    bus_xfer(0, 1'b1, Base + 32'h1, 3'b001, 32'hFFFF_FFFF, w, rf, rl, rd);
    checks++; if (w !== exp_w) begin errors++;
      $display("FAIL misalign_waits: got %0d want %0d", w, exp_w); end
    checks++; if (rf !== exp_r) begin errors++;
      $display("FAIL misalign_resp_first: got %0b want %0b", rf, exp_r); end
    checks++; if (rl !== exp_r) begin errors++;
      $display("FAIL misalign_resp_last: got %0b want %0b", rl, exp_r); end
    bus_xfer(0, 1'b0, Base, 3'b010, 32'h0, w, rf, rl, rd);
    checks++; if (rd !== 32'hCAFE_1234) begin errors++;
      $display("FAIL misalign_ram_kept: got %h want cafe1234", rd); end
  endtask

  task automatic test_out_of_range();
    int w; logic rf, rl; logic [31:0] rd;
    bus_xfer(0, 1'b0, Base + 32'h1000, 3'b010, 32'h0, w, rf, rl, rd);
`ifdef DMEM_ERR_RESP_EN
    checks++; if (w !== 1) begin errors++;
      $display("FAIL oor_waits: got %0d want 1", w); end
    checks++; if (rf !== 1'b1) begin errors++;
      $display("FAIL oor_resp_first: got %0b want 1", rf); end
    checks++; if (rl !== 1'b1) begin errors++;
      $display("FAIL oor_resp_last: got %0b want 1", rl); end
`else
    checks++; if (w !== 0) begin errors++;
      $display("FAIL oor_waits: got %0d want 0", w); end
    checks++; if (rl !== 1'b0) begin errors++;
      $display("FAIL oor_resp: got %0b want 0", rl); end
    checks++; if (rd !== 32'h0) begin errors++;
      $display("FAIL oor_rdata: got %h want 00000000", rd); end
`endif
  endtask

  task automatic test_hready_ignore();
    int w; logic rf, rl; logic [31:0] rd;
    bus_xfer(0, 1'b1, Base + 32'h30, 3'b010, 32'h1357_9BDF, w, rf, rl, rd);
    hready_gate = 1'b0;
    set_addr(0, Base + 32'h30, 1'b1, 3'b010, 2'b10);
    hwdata = 32'hFFFF_FFFF;
    repeat (2) begin @(posedge clk); #1; end
    hready_gate = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    bus_xfer(0, 1'b0, Base + 32'h30, 3'b010, 32'h0, w, rf, rl, rd);
    checks++; if (rd !== 32'h1357_9BDF) begin errors++;
      $display("FAIL hready_low_ignored: got %h want 13579bdf", rd); end
  endtask

  task automatic test_reset_mid_write();
    int w; logic rf, rl; logic [31:0] rd;
    bus_xfer(1, 1'b1, Base + 32'h20, 3'b010, 32'h0BAD_F00D, w, rf, rl, rd);
    set_addr(1, Base + 32'h20, 1'b1, 3'b010, 2'b10);
    @(posedge clk); #1;
    drive_idle();
    hwdata = 32'hFFFF_FFFF;
    checks++; if (hreadyout1 !== 1'b0) begin errors++;
      $display("FAIL mid_write_waiting: got %0b want 0", hreadyout1); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (hreadyout1 !== 1'b1) begin errors++;
      $display("FAIL mid_reset_ready: got %0b want 1", hreadyout1); end
    checks++; if (hresp1 !== 1'b0) begin errors++;
      $display("FAIL mid_reset_resp: got %0b want 0", hresp1); end
    checks++; if (hrdata1 !== 32'h0) begin errors++;
      $display("FAIL mid_reset_rdata: got %h want 00000000", hrdata1); end
    rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    bus_xfer(1, 1'b0, Base + 32'h20, 3'b010, 32'h0, w, rf, rl, rd);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++;
      $display("FAIL mid_reset_ram_kept: got %h want 0badf00d", rd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_stm_wait_states();
    test_fault_align();
    test_out_of_range();
    test_hready_ignore();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
